// File: rtl/uio_cfg_sequencer.sv
// Serial configuration sequencer: shifts in 10-bit frames (2-bit address, 8-bit data, MSB first)
// and commits the data to the uio output-enable, output-data or datapath-mode register.
module uio_cfg_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_bit,
  input  logic       ser_valid,
  input  logic       ser_abort,
  input  logic       err_clr,
  output logic [7:0] oe,
  output logic [7:0] out_data,
  output logic [1:0] mode,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned FRAME_BITS = 10;
  localparam logic [3:0]  LastBit    = 4'(FRAME_BITS);
  localparam logic [7:0]  TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [9:0]  frame_q, frame_d;
  logic [7:0]  oe_q, oe_d;
  logic [7:0]  out_q, out_d;
  logic [1:0]  mode_q, mode_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        err_set;
  logic [7:0]  gap_inc;

  // Saturating so a huge TIMEOUT can never be skipped by a wrap.
  assign gap_inc = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    frame_d = frame_q;
    oe_d    = oe_q;
    out_d   = out_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ser_valid && !ser_abort) begin
          frame_d = {9'b0, ser_bit};
          cnt_d   = 4'd1;
          gap_d   = 8'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (ser_abort) begin
          state_d = StIdle;
        end else if (ser_valid) begin
          frame_d = {frame_q[8:0], ser_bit};
          cnt_d   = cnt_q + 4'd1;
          gap_d   = 8'd0;
          if (cnt_q + 4'd1 == LastBit) begin
            state_d = StCommit;
          end
        end else begin
          gap_d = gap_inc;
          if (gap_inc >= TimeoutVal) begin
            state_d = StIdle;
            err_set = 1'b1;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
        if (!ser_abort) begin
          done_d = 1'b1;
          unique case (frame_q[9:8])
            2'd0: oe_d    = frame_q[7:0];
            2'd1: out_d   = frame_q[7:0];
            2'd2: mode_d  = frame_q[1:0];
            2'd3: err_set = 1'b1;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase

    // A set event wins over a simultaneous clear.
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      gap_q   <= 8'd0;
      frame_q <= 10'd0;
      oe_q    <= 8'h00;
      out_q   <= 8'h00;
      mode_q  <= 2'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign oe       = oe_q;
  assign out_data = out_q;
  assign mode     = mode_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uio_cfg_sequencer.sv
// Bench for uio_cfg_sequencer: directed scenarios plus randomized frames, each cycle compared
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_uio_cfg_sequencer;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst_n, ser_bit, ser_valid, ser_abort, err_clr;
  logic [7:0] oe, out_data;
  logic [1:0] mode;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame collection as integers.
  int m_phase;  // 0 idle, 1 collecting bits, 2 commit pending
  int m_val, m_nbits, m_gap;
  int m_oe, m_out, m_mode, m_done, m_err;

  uio_cfg_sequencer #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ser_bit  (ser_bit),
    .ser_valid(ser_valid),
    .ser_abort(ser_abort),
    .err_clr  (err_clr),
    .oe       (oe),
    .out_data (out_data),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input bit b, input bit a, input bit c, input bit r);
    int set_err;
    int addr, data;
    set_err = 0;
    if (!r) begin
      m_phase = 0; m_val = 0; m_nbits = 0; m_gap = 0;
      m_oe = 0; m_out = 0; m_mode = 0; m_done = 0; m_err = 0;
      return;
    end
    m_done = 0;
    case (m_phase)
      0: if (v && !a) begin
        m_val = int'(b); m_nbits = 1; m_gap = 0; m_phase = 1;
      end
      1: begin
        if (a) m_phase = 0;
        else if (v) begin
          m_val = m_val * 2 + int'(b);
          m_nbits++;
          m_gap = 0;
          if (m_nbits == 10) m_phase = 2;
        end else begin
          if (m_gap < 255) m_gap++;
          if (m_gap >= TO) begin
            m_phase = 0;
            set_err = 1;
          end
        end
      end
      default: begin
        m_phase = 0;
        if (!a) begin
          addr = m_val / 256;
          data = m_val % 256;
          m_done = 1;
          if (addr == 0) m_oe = data;
          else if (addr == 1) m_out = data;
          else if (addr == 2) m_mode = data % 4;
          else set_err = 1;
        end
      end
    endcase
    if (set_err != 0) m_err = 1;
    else if (c) m_err = 0;
  endtask

  task automatic step(input bit v, input bit b, input bit a, input bit c, input bit r);
    @(negedge clk);
    ser_valid = v; ser_bit = b; ser_abort = a; err_clr = c; rst_n = r;
    @(posedge clk);
    model_edge(v, b, a, c, r);
    #1;
    check("oe",       32'(oe),       32'(m_oe));
    check("out_data", 32'(out_data), 32'(m_out));
    check("mode",     32'(mode),     32'(m_mode));
    check("busy",     32'(busy),     32'(m_phase != 0));
    check("done",     32'(done),     32'(m_done));
    check("err",      32'(err),      32'(m_err));
  endtask

  // abort_at: bit index (0..9) at which ser_abort replaces the bit, or -1.
  task automatic send_frame(input logic [1:0] addr, input logic [7:0] data, input int gap,
                            input int abort_at, input bit commit_abort, input bit commit_clr,
                            input bit rnd);
    logic [9:0] f;
    bit c;
    f = {addr, data};
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          c = rnd && ($urandom_range(0, 7) == 0);
          step(1'b0, 1'($urandom), 1'b0, c, 1'b1);
        end
      end
      if (i == abort_at) begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        return;
      end
      c = rnd && ($urandom_range(0, 7) == 0);
      step(1'b1, f[9-i], 1'b0, c, 1'b1);
    end
    // COMMIT cycle; any ser_valid here is dropped by the DUT.
    c = commit_clr || (rnd && ($urandom_range(0, 7) == 0));
    step(rnd ? 1'($urandom) : 1'b0, 1'($urandom), commit_abort, c, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ser_bit = 1'b0; ser_valid = 1'b0; ser_abort = 1'b0; err_clr = 1'b0;
    m_phase = 0; m_val = 0; m_nbits = 0; m_gap = 0;
    m_oe = 0; m_out = 0; m_mode = 0; m_done = 0; m_err = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_oe", 32'(oe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // oe = 0xA5
    send_frame(2'd0, 8'hA5, 0, -1, 1'b0, 1'b0, 1'b0);
    check("a5_oe", 32'(oe), 32'hA5);
    check("a5_done", 32'(done), 32'h1);
    check("a5_out", 32'(out_data), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("a5_done_drop", 32'(done), 32'h0);

    // gaps of 3 cycles, then mode
    send_frame(2'd1, 8'h3C, 3, -1, 1'b0, 1'b0, 1'b0);
    check("3c_out", 32'(out_data), 32'h3C);
    check("3c_err", 32'(err), 32'h0);
    send_frame(2'd2, 8'hFE, 0, -1, 1'b0, 1'b0, 1'b0);
    check("fe_mode", 32'(mode), 32'h2);

    // timeout boundary: 14 idle keeps the frame, 15th expires it
    for (int i = 0; i < 5; i++) step(1'b1, 1'(i & 1), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("gap14_busy", 32'(busy), 32'h1);
    check("gap14_err", 32'(err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_err", 32'(err), 32'h1);
    check("to_oe", 32'(oe), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_err", 32'(err), 32'h0);
    send_frame(2'd0, 8'h0F, 0, -1, 1'b0, 1'b0, 1'b0);
    check("0f_oe", 32'(oe), 32'h0F);

    // bad address
    send_frame(2'd3, 8'h55, 0, -1, 1'b0, 1'b0, 1'b0);
    check("a3_done", 32'(done), 32'h1);
    check("a3_err", 32'(err), 32'h1);
    check("a3_oe", 32'(oe), 32'h0F);
    check("a3_mode", 32'(mode), 32'h2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(2'd3, 8'h55, 0, -1, 1'b0, 1'b1, 1'b0);
    check("a3_clr_same", 32'(err), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // abort mid-frame, then clean frame
    send_frame(2'd0, 8'hFF, 0, 7, 1'b0, 1'b0, 1'b0);
    check("abort_busy", 32'(busy), 32'h0);
    send_frame(2'd0, 8'h81, 0, -1, 1'b0, 1'b0, 1'b0);
    check("81_oe", 32'(oe), 32'h81);
    send_frame(2'd0, 8'h00, 0, -1, 1'b1, 1'b0, 1'b0);
    check("cabort_done", 32'(done), 32'h0);
    check("cabort_oe", 32'(oe), 32'h81);
    // abort in idle swallows a simultaneous bit
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("idle_abort_busy", 32'(busy), 32'h0);

    // reset mid-frame
    send_frame(2'd0, 8'hA5, 0, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mrst_oe", 32'(oe), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    send_frame(2'd1, 8'h42, 0, -1, 1'b0, 1'b0, 1'b0);
    check("mrst_out", 32'(out_data), 32'h42);

    // randomized frames with gaps near the timeout, aborts, clears, resets
    for (int n = 0; n < 80; n++) begin
      int gap, ab, idle;
      gap  = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO) : $urandom_range(0, 3);
      ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1;
      idle = $urandom_range(0, 2);
      send_frame(2'($urandom), 8'($urandom), gap, ab, $urandom_range(0, 15) == 0, 1'b0, 1'b1);
      for (int i = 0; i < idle; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 3) == 0),
                                          1'($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 19) == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
